// File: rtl/multibyte_addsub_seq.sv
// Multi-precision add/subtract engine: streams a wide operand pair through an
// 8-bit add/sub slice one byte per clock, LSB first, and reassembles the result.
module multibyte_addsub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  m,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   s,
    output logic                  c7,
    output logic                  cout,
    output logic                  overflow
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               m_q, m_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       s_q, s_d;
    logic               c7_q, c7_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [7:0]         a_byte, b_byte;
    logic [9:0]         slice;

    // 8-bit slice a + (b ^ {8{m}}) + cin; returns {cout, c7, sum}.
    function automatic logic [9:0] addsub_byte(input logic [7:0] ab, input logic [7:0] bb,
                                               input logic mode, input logic cin);
        logic [7:0] bi;
        logic [7:0] lo;
        logic [8:0] full;
        bi   = bb ^ {8{mode}};
        lo   = {1'b0, ab[6:0]} + {1'b0, bi[6:0]} + {7'd0, cin};
        full = {1'b0, ab} + {1'b0, bi} + {8'd0, cin};
        return {full[8], lo[7], full[7:0]};
    endfunction

    assign a_byte = a_q[8*int'(idx_q) +: 8];
    assign b_byte = b_q[8*int'(idx_q) +: 8];
    assign slice  = addsub_byte(a_byte, b_byte, m_q, carry_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        m_d     = m_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c7_d    = c7_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    carry_d = m;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[8*int'(idx_q) +: 8] = slice[7:0];
                carry_d                 = slice[9];
                if (idx_q == IDX_W'(NBYTES - 1)) begin
                    c7_d    = slice[8];
                    cout_d  = slice[9];
                    ovf_d   = slice[8] ^ slice[9];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            m_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c7_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c7_q    <= c7_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN) || (state_q == DONE);
    assign done     = (state_q == DONE);
    assign s        = s_q;
    assign c7       = c7_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_multibyte_addsub_seq.sv
// Scoreboard bench for multibyte_addsub_seq: a wide-arithmetic reference model
// predicts each result at accept time; results are compared when done pulses.
module tb_multibyte_addsub_seq;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         m = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, c7, cout, overflow;
    logic [W-1:0] s;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c7;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;

    multibyte_addsub_seq #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .a(a), .b(b),
        .busy(busy), .done(done), .s(s), .c7(c7), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic mv);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb   = mv ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, mv};
        low  = {1'b0, av[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, mv};
        e.s    = full[W-1:0];
        e.cout = full[W];
        e.c7   = low[W-1];
        e.ovf  = low[W-1] ^ full[W];
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("s",        64'(s),        64'(e.s));
                check("c7",       64'(c7),       64'(e.c7));
                check("cout",     64'(cout),     64'(e.cout));
                check("overflow", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    // Drives one operation from IDLE and returns on the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic mv);
        int lat;
        @(negedge clk);
        a = av; b = bv; m = mv; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(av, bv, mv));
        #1;
        start = 1'b0;
        a = ~av; b = ~bv; m = ~mv;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) check("busy_after_accept", 64'(busy), 64'd1);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("latency", 64'(lat), 64'(NBYTES + 1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_s",    64'(s),    64'd0);
        check("rst_flags", {61'd0, c7, cout, overflow}, 64'd0);
        rst = 1'b0;

        run_op(32'h000000FF, 32'h00000001, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
        run_op(32'h00000000, 32'h00000001, 1'b1);
        run_op(32'h80000000, 32'h00000001, 1'b1);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

        // start held high with operands changing every cycle
        @(negedge clk);
        check("idle_after_done", 64'(busy), 64'd0);
        begin
            int base;
            base = done_cnt;
            for (int k = 0; k < 18; k++) begin
                a = W'($urandom);
                b = 32'h12345678;
                m = k[0];
                start = 1'b1;
                if (k % 6 == 0) exp_q.push_back(model(a, b, m));
                @(posedge clk);
                #1;
                @(negedge clk);
                if (k != 17) begin
                    // keep aligned: each iteration spans exactly one clock
                end
                if (k == 17) break;
                #0;
                a = a;
            end
            start = 1'b0;
            repeat (3) @(negedge clk);
            check("held_start_dones", 64'(done_cnt - base), 64'd3);
            check("held_start_queue", 64'(exp_q.size()), 64'd0);
        end

        // mid-operation reset aborts with no done and clears everything
        @(negedge clk);
        a = 32'h0000FFFF; b = 32'h00000001; m = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_s",    64'(s),    64'd0);
        check("abort_flags", {61'd0, c7, cout, overflow}, 64'd0);
        begin
            int base;
            base = done_cnt;
            repeat (8) @(negedge clk);
            check("abort_no_done", 64'(done_cnt - base), 64'd0);
        end
        run_op(32'h000000FF, 32'h00000001, 1'b0);

        repeat (2) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/multibyte_addsub_seq.md
Name: multibyte_addsub_seq

Overview:
- Sequential multi-precision add/subtract engine that sits directly upstream of the team's 8-bit add/sub datapath (a + (b XOR {8{m}}) + m, with c7/cout/overflow).
- Latches a wide operand pair and feeds it to that datapath one byte per clock, LSB byte first, carrying between bytes.
- Reassembles the wide sum and wide flags, then reports completion with a done pulse.
- Lets the 8-bit adder serve 16/32/64-bit arithmetic without a wider carry chain.

Parameters:
NBYTES, 4, number of operand bytes processed per operation (legal ≥ 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
m  input  1  mode: 0 = a+b, 1 = a−b (two's complement)
a  input  8*NBYTES  operand A, latched on accepted start
b  input  8*NBYTES  operand B, latched on accepted start
busy  output  1  high from the cycle after accept until done cycle inclusive
done  output  1  one-cycle pulse, result valid
s  output  8*NBYTES  result, held until next accepted start
c7  output  1  carry into MSB of final byte
cout  output  1  carry out of final byte (m=1: 1 = no borrow)
overflow  output  1  c7 XOR cout of final byte

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset (rst=1 at a clk edge):
  - state→IDLE.
  - busy, done, s, c7, cout, overflow → 0.
  - Internal byte index and carry → 0.
  - Reset overrides start and any in-flight operation. Mid-operation reset aborts with no done and leaves s=0.
- States:
  - IDLE: start=1 → latch a, b, m; carry←m; idx←0; →RUN. Otherwise stay.
  - RUN:
    - Each cycle: byte k = idx.
    - bi = b[k] XOR {8{m_latched}}.
    - {c, sum} = a[k] + bi + carry (9-bit).
    - s[8k+7:8k] ← sum; carry ← c.
    - When idx = NBYTES−1: also c7 ← carry into bit 7 of that byte; cout ← c; overflow ← c7 XOR c; →DONE.
    - Otherwise idx←idx+1.
  - DONE: done=1 for exactly this cycle; →IDLE.
- Latency: start accepted at edge T → done high in cycle T+NBYTES+1. A new start is accepted no earlier than the edge after done.
- busy = (state==RUN || state==DONE).
- start is ignored while busy, including in the DONE cycle. It is not queued.
- Operand changes after acceptance have no effect.
- s is updated byte-wise during RUN; upper bytes still hold the previous result until overwritten. Consumers sample s only on done.
- c7/cout/overflow hold their previous values until the final byte's cycle.
- Wrap-around: the sum is modulo 2^(8*NBYTES). The final carry is reported only via cout.
- Byte-internal arithmetic must match the 8-bit datapath exactly. An implementation may instantiate it directly, feeding m for byte 0 and the registered carry thereafter as its carry-in.

Test Plan (NBYTES=4):
1. a=0x000000FF, b=0x00000001, m=0, start → done at T+5; s=0x00000100, c7=0, cout=0, overflow=0. Checks the inter-byte carry chain.
2. a=0x7FFFFFFF, b=0x00000001, m=0 → s=0x80000000, c7=1, cout=0, overflow=1.
3. a=0x00000000, b=0x00000001, m=1 → s=0xFFFFFFFF, cout=0 (borrow), overflow=0.
4. a=0x80000000, b=0x00000001, m=1 → s=0x7FFFFFFF, c7=0, cout=1, overflow=1.
5. a=0xFFFFFFFF, b=0xFFFFFFFF, m=0 → s=0xFFFFFFFE, cout=1, overflow=0.
   - Hold start=1 continuously with changing a: exactly one done per 6 cycles.
   - s reflects the operands latched at each accept.
6. Start an op, assert rst for one cycle two cycles later → no done; busy=0, s=0 and all flags 0 on the next cycle. A fresh start then completes correctly (rerun test 1).
